// File: rtl/core_ctrl_seq.sv
// RV64IM control sequencer: holds one accepted instruction, decodes it into
// datapath controls and stalls upstream while a multiply/divide is running.
module core_ctrl_seq #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  input  logic        flush_i,
  input  logic [2:0]  branch_judgment,
  output logic        ctrl_valid_o,
  output logic        pc_src,
  output logic        idx_src,
  output logic        alu_src,
  output logic        alu_w_sext,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic [2:0]  read_type,
  output logic [1:0]  write_type,
  output logic [2:0]  mem2reg,
  output logic        illegal_o,
  output logic        mdu_start_o,
  output logic        mdu_div_o,
  output logic        mdu_abort_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [7:0] MUL_CNT = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_CYCLES - 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        start_q, start_d;

  logic accept, inIsMdu;
  assign accept  = instr_valid_i & instr_ready_o;
  assign inIsMdu = ((instr_i[6:0] == 7'b0110011) || (instr_i[6:0] == 7'b0111011)) &&
                   (instr_i[31:25] == 7'b0000001);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      hold_q  <= NOP;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      start_q <= start_d;
    end
  end

  // A flush drops both the in-flight MDU op and any instruction offered alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    start_d = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        BUSY: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = DONE;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          if (accept) begin
            hold_d = instr_i;
            if (inIsMdu) begin
              state_d = BUSY;
              cnt_d   = instr_i[14] ? DIV_CNT : MUL_CNT;
              start_d = 1'b1;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  logic [6:0] op;
  logic [2:0] f3;
  logic isR, isI, isLoad, isStore, isBranch, isJal, isJalr, isLui, isAuipc, legal;
  logic wOp, judge;
  logic unused_hold;

  assign op          = hold_q[6:0];
  assign f3          = hold_q[14:12];
  assign unused_hold = ^{hold_q[24:15], hold_q[11:7]};

  assign isR      = (op == 7'b0110011) || (op == 7'b0111011);
  assign isI      = (op == 7'b0010011) || (op == 7'b0011011);
  assign isLoad   = (op == 7'b0000011);
  assign isStore  = (op == 7'b0100011);
  assign isBranch = (op == 7'b1100011);
  assign isJal    = (op == 7'b1101111);
  assign isJalr   = (op == 7'b1100111);
  assign isLui    = (op == 7'b0110111);
  assign isAuipc  = (op == 7'b0010111);
  assign legal    = isR | isI | isLoad | isStore | isBranch | isJal | isJalr | isLui | isAuipc;

  assign wOp = (hold_q[25] & f3[2]) | (~hold_q[25] & ~f3[1] & f3[0]) | (f3 == 3'b000);

  always_comb begin
    judge = 1'b0;
    case (f3)
      3'd0:    judge =  branch_judgment[2];
      3'd1:    judge = ~branch_judgment[2];
      3'd4:    judge =  branch_judgment[1];
      3'd5:    judge = ~branch_judgment[1];
      3'd6:    judge =  branch_judgment[0];
      3'd7:    judge = ~branch_judgment[0];
      default: judge = 1'b0;
    endcase
  end

  assign ctrl_valid_o = valid_q;
  assign alu_op       = {isI, isR};
  assign alu_src      = isI | isLoad | isStore;
  assign idx_src      = isJalr;
  assign alu_w_sext   = (isR | isI) & op[3] & wOp;
  assign mem_read     = valid_q & isLoad;
  assign mem_write    = valid_q & isStore;
  assign reg_write    = valid_q & (isR | isI | isLoad | isJal | isJalr | isLui | isAuipc);
  assign read_type    = legal ? f3 : 3'b000;
  assign write_type   = legal ? f3[1:0] : 2'b00;
  assign mem2reg      = legal ? {op[5], op[2], isLoad | isJal | isJalr | isAuipc} : 3'b000;
  assign illegal_o    = ~legal;
  assign pc_src       = valid_q & legal & op[6] & (op[2] | judge);

  assign instr_ready_o = (state_q != BUSY);
  assign stall_o       = (state_q == BUSY);
  assign mdu_start_o   = start_q & (state_q == BUSY);
  assign mdu_div_o     = (state_q == BUSY) & hold_q[14];
  assign mdu_abort_o   = (state_q == BUSY) & flush_i & ~rst;

endmodule

// File: tb/tb_core_ctrl_seq.sv
// Directed bench for core_ctrl_seq: decode, branch resolution, MDU sequencing,
// flush and reset behaviour with hand-computed expectations.
module tb_core_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrValid;
  logic [31:0] instr;
  logic        instrReady;
  logic        flush;
  logic [2:0]  branchJudgment;
  logic        ctrlValid, pcSrc, idxSrc, aluSrc, aluWSext, memRead, memWrite, regWrite;
  logic [1:0]  aluOp;
  logic [2:0]  readType;
  logic [1:0]  writeType;
  logic [2:0]  mem2reg;
  logic        illegal, mduStart, mduDiv, mduAbort, stall;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] BNE   = 32'h00209463;
  localparam logic [31:0] MUL   = 32'h023100B3;
  localparam logic [31:0] DIV   = 32'h0231C0B3;
  localparam logic [31:0] ILL   = 32'h0000007F;
  localparam logic [31:0] ADDIW = 32'h0011009B;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] JAL   = 32'h008000EF;

  core_ctrl_seq #(.MUL_CYCLES(3), .DIV_CYCLES(33)) dut (
    .clk(clk), .rst(rst),
    .instr_valid_i(instrValid), .instr_i(instr), .instr_ready_o(instrReady),
    .flush_i(flush), .branch_judgment(branchJudgment),
    .ctrl_valid_o(ctrlValid), .pc_src(pcSrc), .idx_src(idxSrc), .alu_src(aluSrc),
    .alu_w_sext(aluWSext), .mem_read(memRead), .mem_write(memWrite), .reg_write(regWrite),
    .alu_op(aluOp), .read_type(readType), .write_type(writeType), .mem2reg(mem2reg),
    .illegal_o(illegal), .mdu_start_o(mduStart), .mdu_div_o(mduDiv),
    .mdu_abort_o(mduAbort), .stall_o(stall)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic fl,
                               input logic [2:0] bj);
    instrValid     = v;
    instr          = ins;
    flush          = fl;
    branchJudgment = bj;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    step();
    checkOutput("rst_valid", {31'b0, ctrlValid}, 32'd0);
    checkOutput("rst_ready", {31'b0, instrReady}, 32'd1);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_start", {31'b0, mduStart}, 32'd0);
    checkOutput("rst_abort", {31'b0, mduAbort}, 32'd0);
    checkOutput("rst_illegal", {31'b0, illegal}, 32'd0);
    checkOutput("rst_pcsrc", {31'b0, pcSrc}, 32'd0);
    rst = 1'b0;
    step();

    // add x1,x2,x3
    applyStimulus(1'b1, ADD, 1'b0, 3'b000);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    checkOutput("add_valid", {31'b0, ctrlValid}, 32'd1);
    checkOutput("add_aluop", {30'b0, aluOp}, 32'd1);
    checkOutput("add_regwrite", {31'b0, regWrite}, 32'd1);
    checkOutput("add_mem2reg", {29'b0, mem2reg}, 32'd4);
    checkOutput("add_wsext", {31'b0, aluWSext}, 32'd0);
    checkOutput("add_alusrc", {31'b0, aluSrc}, 32'd0);
    step();
    checkOutput("add_valid_drop", {31'b0, ctrlValid}, 32'd0);
    checkOutput("add_regwrite_drop", {31'b0, regWrite}, 32'd0);

    // beq with eq=1 and eq=0, then bne
    applyStimulus(1'b1, BEQ, 1'b0, 3'b000);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b100);
    #1;
    checkOutput("beq_taken", {31'b0, pcSrc}, 32'd1);
    branchJudgment = 3'b000;
    #1;
    checkOutput("beq_not_taken", {31'b0, pcSrc}, 32'd0);
    checkOutput("beq_regwrite", {31'b0, regWrite}, 32'd0);
    applyStimulus(1'b1, BNE, 1'b0, 3'b100);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b100);
    checkOutput("bne_eq", {31'b0, pcSrc}, 32'd0);
    branchJudgment = 3'b011;
    #1;
    checkOutput("bne_ne", {31'b0, pcSrc}, 32'd1);
    step();
    checkOutput("bne_idle_pcsrc", {31'b0, pcSrc}, 32'd0);

    // back-to-back accepts: add, jal, sw
    applyStimulus(1'b1, ADD, 1'b0, 3'b000);
    step();
    applyStimulus(1'b1, JAL, 1'b0, 3'b000);
    checkOutput("b2b_valid0", {31'b0, ctrlValid}, 32'd1);
    step();
    applyStimulus(1'b1, SW, 1'b0, 3'b000);
    checkOutput("b2b_valid1", {31'b0, ctrlValid}, 32'd1);
    checkOutput("jal_pcsrc", {31'b0, pcSrc}, 32'd1);
    checkOutput("jal_mem2reg", {29'b0, mem2reg}, 32'd7);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    checkOutput("b2b_valid2", {31'b0, ctrlValid}, 32'd1);
    checkOutput("sw_memwrite", {31'b0, memWrite}, 32'd1);
    checkOutput("sw_writetype", {30'b0, writeType}, 32'd2);
    checkOutput("sw_alusrc", {31'b0, aluSrc}, 32'd1);
    checkOutput("sw_regwrite", {31'b0, regWrite}, 32'd0);
    step();
    checkOutput("sw_memwrite_drop", {31'b0, memWrite}, 32'd0);

    // mul: three BUSY cycles then DONE
    applyStimulus(1'b1, MUL, 1'b0, 3'b000);
    step();
    applyStimulus(1'b1, ADD, 1'b0, 3'b000);
    checkOutput("mul_c1_stall", {31'b0, stall}, 32'd1);
    checkOutput("mul_c1_start", {31'b0, mduStart}, 32'd1);
    checkOutput("mul_c1_ready", {31'b0, instrReady}, 32'd0);
    checkOutput("mul_c1_valid", {31'b0, ctrlValid}, 32'd0);
    checkOutput("mul_c1_div", {31'b0, mduDiv}, 32'd0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    checkOutput("mul_c2_stall", {31'b0, stall}, 32'd1);
    checkOutput("mul_c2_start", {31'b0, mduStart}, 32'd0);
    step();
    checkOutput("mul_c3_stall", {31'b0, stall}, 32'd1);
    checkOutput("mul_c3_valid", {31'b0, ctrlValid}, 32'd0);
    step();
    checkOutput("mul_c4_valid", {31'b0, ctrlValid}, 32'd1);
    checkOutput("mul_c4_stall", {31'b0, stall}, 32'd0);
    checkOutput("mul_c4_ready", {31'b0, instrReady}, 32'd1);
    checkOutput("mul_c4_regwrite", {31'b0, regWrite}, 32'd1);
    step();
    checkOutput("mul_c5_valid", {31'b0, ctrlValid}, 32'd0);

    // div flushed on its tenth BUSY cycle
    applyStimulus(1'b1, DIV, 1'b0, 3'b000);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    checkOutput("div_c1_div", {31'b0, mduDiv}, 32'd1);
    checkOutput("div_c1_start", {31'b0, mduStart}, 32'd1);
    for (int i = 2; i <= 10; i++) begin
      step();
      checkOutput("div_busy_valid", {31'b0, ctrlValid}, 32'd0);
    end
    checkOutput("div_c10_stall", {31'b0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("div_abort", {31'b0, mduAbort}, 32'd1);
    step();
    flush = 1'b0;
    #1;
    checkOutput("div_flush_stall", {31'b0, stall}, 32'd0);
    checkOutput("div_flush_ready", {31'b0, instrReady}, 32'd1);
    checkOutput("div_flush_abort", {31'b0, mduAbort}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      step();
      checkOutput("div_after_valid", {31'b0, ctrlValid}, 32'd0);
    end

    // illegal opcode, addiw
    applyStimulus(1'b1, ILL, 1'b0, 3'b111);
    step();
    applyStimulus(1'b1, ADDIW, 1'b0, 3'b111);
    checkOutput("ill_illegal", {31'b0, illegal}, 32'd1);
    checkOutput("ill_regwrite", {31'b0, regWrite}, 32'd0);
    checkOutput("ill_memwrite", {31'b0, memWrite}, 32'd0);
    checkOutput("ill_memread", {31'b0, memRead}, 32'd0);
    checkOutput("ill_pcsrc", {31'b0, pcSrc}, 32'd0);
    checkOutput("ill_mem2reg", {29'b0, mem2reg}, 32'd0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    checkOutput("addiw_wsext", {31'b0, aluWSext}, 32'd1);
    checkOutput("addiw_aluop", {30'b0, aluOp}, 32'd2);
    checkOutput("addiw_illegal", {31'b0, illegal}, 32'd0);
    step();

    // reset in the middle of a mul
    applyStimulus(1'b1, MUL, 1'b0, 3'b000);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    step();
    rst = 1'b1;
    #1;
    checkOutput("rstbusy_abort", {31'b0, mduAbort}, 32'd0);
    step();
    rst = 1'b0;
    checkOutput("rstbusy_ready", {31'b0, instrReady}, 32'd1);
    checkOutput("rstbusy_stall", {31'b0, stall}, 32'd0);
    checkOutput("rstbusy_start", {31'b0, mduStart}, 32'd0);
    checkOutput("rstbusy_valid", {31'b0, ctrlValid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rstbusy_after_valid", {31'b0, ctrlValid}, 32'd0);
    end

    // flush coincident with accepts
    applyStimulus(1'b1, MUL, 1'b1, 3'b000);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    checkOutput("flacc_start", {31'b0, mduStart}, 32'd0);
    checkOutput("flacc_stall", {31'b0, stall}, 32'd0);
    checkOutput("flacc_valid", {31'b0, ctrlValid}, 32'd0);
    checkOutput("flacc_ready", {31'b0, instrReady}, 32'd1);
    step();
    checkOutput("flacc_start_later", {31'b0, mduStart}, 32'd0);
    applyStimulus(1'b1, ADD, 1'b1, 3'b000);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 3'b000);
    checkOutput("flacc_add_valid", {31'b0, ctrlValid}, 32'd0);
    checkOutput("flacc_add_regwrite", {31'b0, regWrite}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_ctrl_seq.md
CORE_CTRL_SEQ -- requirements
Module: core_ctrl_seq

Interface
REQ-001 Parameter MUL_CYCLES, default 3: busy cycles for an M-extension multiply (funct3[2]=0); legal range is 1..255.
REQ-002 Parameter DIV_CYCLES, default 33: busy cycles for an M-extension divide/remainder (funct3[2]=1); legal range is 1..255.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid_i  in  1  instr_i holds an instruction.
- instr_i  in  32  RV64IM instruction.
- instr_ready_o  out  1  block can accept an instruction this cycle.
- flush_i  in  1  discard the held or in-flight instruction.
- branch_judgment  in  3  {eq, lt, ltu} compare flags from EXU.
- ctrl_valid_o  out  1  control outputs below are meaningful.
- pc_src, idx_src, alu_src, alu_w_sext, mem_read, mem_write, reg_write  out  1 each.
- alu_op  out  2.
- read_type  out  3.
- write_type  out  2.
- mem2reg  out  3.
- illegal_o  out  1  the held opcode is not in REQ-006.
- mdu_start_o  out  1  one-cycle start pulse to the multiply/divide unit.
- mdu_div_o  out  1  operation is a divide/remainder.
- mdu_abort_o  out  1  one-cycle pulse when an MDU operation is cancelled.
- stall_o  out  1  upstream must hold the fetched instruction.

Function
REQ-004 The block SHALL accept an instruction when instr_valid_i and instr_ready_o are both 1, and SHALL register it into a hold register at that rising edge.
REQ-005 instr_ready_o SHALL equal (state != BUSY); stall_o SHALL equal (state == BUSY).
REQ-006 Decode of opcode = instr[6:0] from the hold register:
- R = 0110011 or 0111011.
- I = 0010011 or 0011011.
- LOAD = 0000011.
- STORE = 0100011.
- BRANCH = 1100011.
- JAL = 1101111.
- JALR = 1100111.
- LUI = 0110111.
- AUIPC = 0010111.
- Any other opcode sets illegal_o=1 and forces every other control output to 0.
REQ-007 The control outputs SHALL decode as follows:
- alu_op = {I, R}; alu_src = I|LOAD|STORE; idx_src = JALR.
- mem_read = LOAD; mem_write = STORE.
- read_type = funct3; write_type = funct3[1:0].
- mem2reg = {op[5], op[2], LOAD|JAL|JALR|AUIPC}.
- reg_write = R|I|LOAD|JAL|JALR|LUI|AUIPC.
REQ-008 alu_w_sext SHALL equal (R|I) & op[3] & w, where w = (instr[25]&f3[2]) | (~instr[25]&~f3[1]&f3[0]) | (f3==000).
REQ-009 judge SHALL select from branch_judgment by funct3:
- 0 -> eq; 1 -> ~eq.
- 4 -> lt; 5 -> ~lt.
- 6 -> ltu; 7 -> ~ltu.
- 2 and 3 -> 0.
REQ-010 pc_src SHALL equal ctrl_valid_o & op[6] & (op[2] | judge); it is combinational on the live branch_judgment.
REQ-011 An MDU instruction is R with instr[31:25]=0000001.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE, with an 8-bit down-counter cnt.
REQ-013 FSM transitions:
- IDLE or DONE, accepting an MDU instruction -> BUSY, with cnt = (funct3[2] ? DIV_CYCLES : MUL_CYCLES) - 1.
- IDLE or DONE, accepting a non-MDU instruction or accepting nothing -> IDLE.
- BUSY with cnt != 0 -> cnt decrements by 1.
- BUSY with cnt == 0 -> DONE.
REQ-014 mdu_start_o SHALL be 1 only in the first BUSY cycle; mdu_div_o SHALL equal the held funct3[2] while in BUSY and 0 otherwise.
REQ-015 For a non-MDU instruction, ctrl_valid_o SHALL be 1 exactly in the cycle after acceptance; if no new instruction is accepted in that cycle, it returns to 0.
REQ-016 For an MDU instruction, ctrl_valid_o SHALL be 0 throughout BUSY and 1 for the single DONE cycle. Latency from the acceptance edge to DONE is N+1 cycles, where N is the selected cycle count.
REQ-017 Back-to-back accepts SHALL keep ctrl_valid_o high continuously, with no bubble.
REQ-018 flush_i=1 SHALL, at the next edge, clear ctrl_valid_o and force state to IDLE.
REQ-019 If flush_i=1 while in BUSY, mdu_abort_o SHALL pulse in that same cycle.
REQ-020 flush_i=1 coincident with an accept SHALL win: the instruction is dropped and no mdu_start_o follows.
REQ-021 Control outputs other than pc_src, illegal_o and the mdu_*/stall signals MAY hold stale values when ctrl_valid_o=0; reg_write and mem_write SHALL be 0 whenever ctrl_valid_o=0.

Reset
REQ-022 While rst=1 at an edge:
- state = IDLE, cnt = 0.
- hold register = 32'h00000013 (NOP).
- ctrl_valid_o, mdu_start_o, mdu_abort_o, illegal_o, stall_o and pc_src = 0.
REQ-023 rst SHALL override flush_i and any accept.
REQ-024 Reset during BUSY SHALL return to IDLE without a mdu_abort_o pulse, and instr_ready_o=1 in the first cycle after reset.

Verification
REQ-025 add x1,x2,x3 (0x003100B3) accepted -> next cycle ctrl_valid_o=1, alu_op=01, reg_write=1, mem2reg=100, alu_w_sext=0.
REQ-026 beq (0x00208463) with branch_judgment=100 -> pc_src=1; the same instruction with 000 -> pc_src=0; bne with 100 -> pc_src=0.
REQ-027 mul (0x023100B3), MUL_CYCLES=3 -> stall_o=1 for 3 cycles, mdu_start_o in the first of them, ctrl_valid_o=1 on cycle 4, instr_ready_o=0 during BUSY.
REQ-028 div (0x0231C0B3), DIV_CYCLES=33, with flush_i on BUSY cycle 10 -> mdu_abort_o=1 in that cycle, IDLE next, ctrl_valid_o never 1.
REQ-029 Opcode 0x7F -> illegal_o=1 with reg_write=mem_write=mem_read=0; addiw (0x0011009B) -> alu_w_sext=1.
REQ-030 rst asserted mid-BUSY of mul, and flush_i coincident with an accept -> all outputs at their reset or zero values, no mdu_start_o.
